// File: rtl/pwm_led_bank.sv
// pwm_led_bank -- bank of N_CH PWM LED drivers that share one prescaler and
// one PWM period counter.
//
// Each channel runs in one of two modes:
//   - static:  a fixed duty.
//   - breathe: the duty ramps 0..ceiling..0, one step per PWM period.
//
// Configuration writes land in a per-channel shadow register. The effective
// duty (eff) is only reloaded from the shadow at a period boundary, so a
// period that is already running never changes shape.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   en            global enable; low freezes timing and blanks LEDs
//   wr_en         one-cycle write strobe
//   wr_ch         target channel; indices >= N_CH are ignored
//   wr_duty       duty (static mode) or ceiling (breathe mode)
//   wr_mode       0 = static, 1 = breathe
//   led           registered PWM outputs, one bit per channel
//   period_start  one-cycle pulse in the first cycle of each PWM period
module pwm_led_bank #(
  parameter int N_CH   = 4,
  parameter int DUTY_W = 8,
  parameter int PRESC  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   wr_en,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] wr_ch,
  input  logic [DUTY_W-1:0]                      wr_duty,
  input  logic                                   wr_mode,
  output logic [N_CH-1:0]                        led,
  output logic                                   period_start
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PS_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESC - 1);
  localparam logic [DUTY_W-1:0] CNT_MAX = '1;
  localparam logic [DUTY_W-1:0] ONE     = DUTY_W'(1);

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              period_start_q, period_start_d;
  logic [N_CH-1:0]   led_q, led_d;
  logic              step;
  logic              wrap;

  // Shared timebase. Dropping en clears both counters, so the first step
  // after en returns comes a full PRESC cycles later from pwm_cnt = 0.
  always_comb begin
    step           = en && (presc_q == PS_LAST);
    wrap           = step && (pwm_cnt_q == CNT_MAX);
    presc_d        = presc_q;
    pwm_cnt_d      = pwm_cnt_q;
    period_start_d = wrap;
    if (!en) begin
      presc_d   = '0;
      pwm_cnt_d = '0;
    end else if (step) begin
      presc_d   = '0;
      pwm_cnt_d = pwm_cnt_q + ONE;
    end else begin
      presc_d   = presc_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      led_q          <= '0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      led_q          <= led_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DUTY_W-1:0] sh_duty_q, sh_duty_d;
      logic              sh_mode_q, sh_mode_d;
      logic [DUTY_W-1:0] eff_q, eff_d;
      logic              dir_q, dir_d;
      logic              wr_hit;
      logic              led_bit_d;

      always_comb begin
        // Out-of-range indices match no channel and are silently dropped.
        wr_hit    = wr_en && (wr_ch == CH_W'(gi));
        sh_duty_d = wr_hit ? wr_duty : sh_duty_q;
        sh_mode_d = wr_hit ? wr_mode : sh_mode_q;
        eff_d     = eff_q;
        dir_d     = dir_q;
        // The boundary update reads the registered shadow, so a write in
        // the same cycle only shows up one period later.
        if (wrap) begin
          if (!sh_mode_q) begin
            eff_d = sh_duty_q;
            // A later switch to breathe starts ramping up from here.
            dir_d = 1'b1;
          end else if (dir_q) begin
            if (eff_q < sh_duty_q) begin
              eff_d = eff_q + ONE;
            end else begin
              dir_d = 1'b0;
              eff_d = (sh_duty_q == '0) ? '0 : sh_duty_q - ONE;
            end
          end else begin
            if (eff_q != '0) begin
              eff_d = eff_q - ONE;
            end else begin
              dir_d = 1'b1;
              eff_d = (sh_duty_q == '0) ? '0 : ONE;
            end
          end
        end
        led_bit_d = en && (pwm_cnt_q < eff_q);
      end

      assign led_d[gi] = led_bit_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          sh_duty_q <= '0;
          sh_mode_q <= 1'b0;
          eff_q     <= '0;
          dir_q     <= 1'b1;
        end else begin
          sh_duty_q <= sh_duty_d;
          sh_mode_q <= sh_mode_d;
          eff_q     <= eff_d;
          dir_q     <= dir_d;
        end
      end
    end
  endgenerate

  assign led          = led_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_led_bank.sv
// Directed testbench for pwm_led_bank with N_CH=4, DUTY_W=4, PRESC=2
// (32-cycle period). A second instance with N_CH=3 provides a channel
// index that is out of range yet still fits the wr_ch port.
module tb_pwm_led_bank;

  logic       clk = 1'b0;
  logic       rst, en, wr_en, wr_mode;
  logic [1:0] wr_ch;
  logic [3:0] wr_duty;
  logic [3:0] led;
  logic       period_start;

  logic       w3_en, w3_mode;
  logic [1:0] w3_ch;
  logic [3:0] w3_duty;
  logic [2:0] led3;
  logic       ps3;

  int checks = 0;
  int errors = 0;

  // Results of the most recent measured period.
  int m_cnt [4];
  int m_run [4];
  int m_ps_mid, m_cnt3, m_ps3;
  bit m_ps_end;
  int w_led_hi;

  always #5 clk = ~clk;

  pwm_led_bank #(.N_CH(4), .DUTY_W(4), .PRESC(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .wr_mode(wr_mode), .led(led), .period_start(period_start)
  );

  pwm_led_bank #(.N_CH(3), .DUTY_W(4), .PRESC(2)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .wr_en(w3_en), .wr_ch(w3_ch),
    .wr_duty(w3_duty), .wr_mode(w3_mode), .led(led3), .period_start(ps3)
  );

  // Called on the negedge where period_start is high. Samples the 32
  // following negedges; the last one must be the next period_start.
  // Optionally issues one write, driven at sample index wr_at.
  task automatic measure(input bit do_wr, input int wr_at, input logic [1:0] ch,
                         input logic [3:0] duty, input logic mode, input bit to3);
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0;
      m_run[c] = 0;
    end
    m_ps_mid = 0; m_ps_end = 1'b0; m_cnt3 = 0; m_ps3 = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (led[c]) begin
          m_cnt[c]++;
          if (m_run[c] == i - 1) m_run[c]++;
        end
      end
      if (period_start) begin
        if (i == 32) m_ps_end = 1'b1;
        else m_ps_mid++;
      end
      if (led3 != 3'b000) m_cnt3++;
      if (ps3) m_ps3++;
      wr_en = 1'b0;
      w3_en = 1'b0;
      if (do_wr && i == wr_at) begin
        if (to3) begin
          w3_en = 1'b1; w3_ch = ch; w3_duty = duty; w3_mode = mode;
        end else begin
          wr_en = 1'b1; wr_ch = ch; wr_duty = duty; wr_mode = mode;
        end
      end
    end
  endtask

  // Waits (bounded) for period_start; n = negedges waited, 0 on timeout.
  task automatic wait_ps(output int n);
    n = 0;
    w_led_hi = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (led != 4'b0000) w_led_hi++;
      if (period_start) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 4'b0000) begin
        errors++; $display("FAIL reset_led: got %b expected 0000", led);
      end
      checks++;
      if (period_start !== 1'b0) begin
        errors++; $display("FAIL reset_ps: got %b expected 0", period_start);
      end
    end
    // Reset must win over en and a write strobe.
    en = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd15; wr_mode = 1'b0;
    @(negedge clk);
    checks++;
    if (led !== 4'b0000 || period_start !== 1'b0) begin
      errors++; $display("FAIL reset_priority: got led=%b ps=%b expected 0000/0", led, period_start);
    end
    rst = 1'b0; wr_en = 1'b0;
    wait_ps(n);
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL first_period_start: got %0d cycles expected 32", n);
    end
  endtask

  task automatic test_idle();
    for (int p = 0; p < 3; p++) begin
      measure(1'b0, 0, 2'd0, 4'd0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (m_cnt[c] !== 0) begin
          errors++; $display("FAIL idle_led ch%0d period %0d: got %0d high expected 0", c, p, m_cnt[c]);
        end
      end
      checks++;
      if (m_ps_end !== 1'b1 || m_ps_mid !== 0) begin
        errors++; $display("FAIL idle_ps period %0d: got end=%0d mid=%0d expected 1/0", p, m_ps_end, m_ps_mid);
      end
    end
  endtask

  task automatic test_static();
    int exp_cnt [4];
    exp_cnt = '{0, 8, 0, 0};
    measure(1'b1, 10, 2'd1, 4'd4, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (m_cnt[c] !== 0) begin
        errors++; $display("FAIL static_midwrite ch%0d: got %0d high expected 0", c, m_cnt[c]);
      end
    end
    for (int p = 0; p < 2; p++) begin
      measure(1'b0, 0, 2'd0, 4'd0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (m_cnt[c] !== exp_cnt[c]) begin
          errors++; $display("FAIL static_high ch%0d period %0d: got %0d expected %0d", c, p, m_cnt[c], exp_cnt[c]);
        end
      end
      checks++;
      if (m_run[1] !== 8) begin
        errors++; $display("FAIL static_run ch1 period %0d: got %0d expected 8", p, m_run[1]);
      end
      checks++;
      if (m_ps_end !== 1'b1 || m_ps_mid !== 0) begin
        errors++; $display("FAIL static_ps period %0d: got end=%0d mid=%0d expected 1/0", p, m_ps_end, m_ps_mid);
      end
    end
  endtask

  task automatic test_breathe();
    int exp2 [7];
    exp2 = '{2, 4, 6, 4, 2, 0, 2};
    measure(1'b1, 5, 2'd2, 4'd3, 1'b1, 1'b0);
    checks++;
    if (m_cnt[2] !== 0) begin
      errors++; $display("FAIL breathe_midwrite ch2: got %0d high expected 0", m_cnt[2]);
    end
    // The last period also switches ch2 back to static duty 0.
    for (int p = 0; p < 7; p++) begin
      measure(p == 6, 3, 2'd2, 4'd0, 1'b0, 1'b0);
      checks++;
      if (m_cnt[2] !== exp2[p]) begin
        errors++; $display("FAIL breathe_ramp period %0d: got %0d high expected %0d", p, m_cnt[2], exp2[p]);
      end
      checks++;
      if (m_cnt[1] !== 8) begin
        errors++; $display("FAIL breathe_ch1_hold period %0d: got %0d expected 8", p, m_cnt[1]);
      end
    end
  endtask

  task automatic test_boundary();
    int exp3 [3];
    exp3 = '{0, 0, 30};
    for (int p = 0; p < 3; p++) begin
      // Write driven at index 31 is sampled on the boundary edge itself.
      measure(p == 0, 31, 2'd3, 4'd15, 1'b0, 1'b0);
      checks++;
      if (m_cnt[3] !== exp3[p]) begin
        errors++; $display("FAIL boundary_ch3 period %0d: got %0d high expected %0d", p, m_cnt[3], exp3[p]);
      end
      checks++;
      if (m_cnt[2] !== 0 || m_cnt[1] !== 8) begin
        errors++; $display("FAIL boundary_others period %0d: got ch1=%0d ch2=%0d expected 8/0", p, m_cnt[1], m_cnt[2]);
      end
    end
    checks++;
    if (m_run[3] !== 30) begin
      errors++; $display("FAIL boundary_run ch3: got %0d expected 30", m_run[3]);
    end
  endtask

  task automatic test_bad_index();
    for (int p = 0; p < 2; p++) begin
      measure(p == 0, 7, 2'd3, 4'd15, 1'b0, 1'b1);
      checks++;
      if (m_cnt3 !== 0) begin
        errors++; $display("FAIL bad_index_led period %0d: got %0d high cycles expected 0", p, m_cnt3);
      end
      checks++;
      if (m_ps3 !== 1) begin
        errors++; $display("FAIL bad_index_ps period %0d: got %0d pulses expected 1", p, m_ps3);
      end
      checks++;
      if (m_cnt[1] !== 8 || m_cnt[3] !== 30) begin
        errors++; $display("FAIL bad_index_main period %0d: got ch1=%0d ch3=%0d expected 8/30", p, m_cnt[1], m_cnt[3]);
      end
    end
  endtask

  task automatic test_enable();
    int n, bad;
    for (int i = 0; i < 10; i++) @(negedge clk);
    en = 1'b0;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (led !== 4'b0000 || period_start !== 1'b0) bad++;
      wr_en = 1'b0;
      // Writes stay live while disabled.
      if (i == 3) begin
        wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd2; wr_mode = 1'b0;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL enable_blank: got %0d active cycles expected 0", bad);
    end
    en = 1'b1;
    wait_ps(n);
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL enable_restart: got %0d cycles expected 32", n);
    end
    measure(1'b0, 0, 2'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (m_cnt[0] !== 4 || m_cnt[1] !== 8 || m_cnt[2] !== 0 || m_cnt[3] !== 30) begin
      errors++; $display("FAIL enable_duties: got %0d/%0d/%0d/%0d expected 4/8/0/30",
                         m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 12; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (led !== 4'b0000 || period_start !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got led=%b ps=%b expected 0000/0", led, period_start);
    end
    rst = 1'b0;
    wait_ps(n);
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL reset_mid_restart: got %0d cycles expected 32", n);
    end
    checks++;
    if (w_led_hi !== 0) begin
      errors++; $display("FAIL reset_mid_eff: got %0d led-active cycles expected 0", w_led_hi);
    end
    measure(1'b0, 0, 2'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3] !== 0) begin
      errors++; $display("FAIL reset_mid_shadow: got %0d/%0d/%0d/%0d expected 0/0/0/0",
                         m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_mode = 1'b0;
    w3_en = 1'b0; w3_ch = '0; w3_duty = '0; w3_mode = 1'b0;
    test_reset();
    test_idle();
    test_static();
    test_breathe();
    test_boundary();
    test_bad_index();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
